// File: rtl/axi8_lite_pkg.sv
// Shared constants and state encoding for the 8-bit AXI4-Lite master and its benches.
package axi8_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_RSP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WR    = ST_WR,
    S_WRESP = ST_WRESP,
    S_RADDR = ST_RADDR,
    S_RDATA = ST_RDATA,
    S_RSP   = ST_RSP
  } m_state_e;

endpackage

// File: rtl/axi8_lite_wdog.sv
// Per-transaction watchdog: counts waiting cycles, cleared on accept and on every handshake.
module axi8_lite_wdog
  import axi8_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;

  assign w_next = r_count + 1'b1;

  // Fires on the edge closing the TIMEOUT-th waiting cycle; a handshake on that edge wins.
  assign o_expired = (TIMEOUT != 0) && i_run && !i_clear && (w_next == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || !i_run) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/axi8_lite_master.sv
// Command-driven single-beat AXI4-Lite initiator with response port and watchdog abort.
module axi8_lite_master
  import axi8_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic                    BREADY,
  input  logic                    BVALID,
  input  logic [1:0]              BRESP,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic                    RREADY,
  input  logic                    RVALID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  output logic                    busy
);

  m_state_e              r_state;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_timeout;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_waiting;
  logic w_expired;

  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign busy      = (r_state != S_IDLE);

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_aw_hs   = r_awvalid && AWREADY;
  assign w_w_hs    = r_wvalid && WREADY;
  assign w_b_hs    = r_bready && BVALID;
  assign w_ar_hs   = r_arvalid && ARREADY;
  assign w_r_hs    = r_rready && RVALID;
  // AW and W retire independently; each is done once its VALID is gone or handshakes now.
  assign w_aw_done = !r_awvalid || w_aw_hs;
  assign w_w_done  = !r_wvalid || w_w_hs;
  assign w_waiting = r_state inside {S_WR, S_WRESP, S_RADDR, S_RDATA};

  axi8_lite_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept || w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs),
    .i_run     (w_waiting),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_awaddr      <= '0;
      r_araddr      <= '0;
      r_wdata       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
    end else if (w_expired) begin
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_timeout <= 1'b1;
      r_rsp_valid   <= 1'b1;
      r_state       <= S_RSP;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end
        end
        S_WR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (w_b_hs) begin
            r_rsp_resp  <= BRESP;
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_r_hs) begin
            r_rsp_rdata <= RDATA;
            r_rsp_resp  <= RRESP;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign AWADDR      = r_awaddr;
  assign AWVALID     = r_awvalid;
  assign WDATA       = r_wdata;
  assign WSTRB       = '1;
  assign WVALID      = r_wvalid;
  assign BREADY      = r_bready;
  assign ARADDR      = r_araddr;
  assign ARVALID     = r_arvalid;
  assign RREADY      = r_rready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_axi8_lite_master.sv
// Directed bench for axi8_lite_master with a configurable slave model and response scoreboard.
module tb_axi8_lite_master;
  import axi8_lite_pkg::*;

  localparam int unsigned AW = 1;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BREADY, BVALID;
  logic          ARVALID, ARREADY, RREADY, RVALID, busy;
  logic [DW-1:0] WDATA, RDATA;
  logic [0:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;

  axi8_lite_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RREADY(RREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: register at addr 0, addr 1 reads back its complement.
  int unsigned aw_dly, w_dly, ar_dly;
  int unsigned aw_wait, w_wait, ar_wait;
  bit          ar_en, b_en, r_force;
  logic [1:0]  b_resp_v, r_resp_v;
  logic [7:0]  r_force_data;
  logic [7:0]  s_mem0 = 8'h00;
  logic        s_aw_got, s_w_got;
  logic [AW-1:0] s_awaddr;
  logic [7:0]  s_wdata;
  logic        t_aw, t_w;
  logic [AW-1:0] t_addr;
  logic [7:0]  t_data;

  assign AWREADY = AWVALID && (aw_wait >= aw_dly);
  assign WREADY  = WVALID && (w_wait >= w_dly);
  assign ARREADY = ar_en && ARVALID && (ar_wait >= ar_dly);
  assign t_aw    = s_aw_got || (AWVALID && AWREADY);
  assign t_w     = s_w_got || (WVALID && WREADY);
  assign t_addr  = (AWVALID && AWREADY) ? AWADDR : s_awaddr;
  assign t_data  = (WVALID && WREADY) ? WDATA : s_wdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_awaddr <= '0; s_wdata <= '0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RDATA <= 8'h00; RRESP <= 2'b00;
    end else begin
      aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
      ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
      if (AWVALID && AWREADY) begin s_aw_got <= 1'b1; s_awaddr <= AWADDR; end
      if (WVALID && WREADY) begin s_w_got <= 1'b1; s_wdata <= WDATA; end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (t_aw && t_w) begin
        if (t_addr == '0) s_mem0 <= t_data;
        s_aw_got <= 1'b0; s_w_got <= 1'b0;
        BVALID <= b_en; BRESP <= b_resp_v;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= r_force ? r_force_data : ((ARADDR != '0) ? ~s_mem0 : s_mem0);
        RRESP  <= r_resp_v;
      end
    end
  end

  // Protocol monitor: handshake edges, VALID drop after handshake, payload stability.
  int unsigned aw_edge, w_edge, b_edge, ar_high, aw_hs_n, ar_hs_n;
  logic p_aw_hs = 0, p_w_hs = 0, p_ar_hs = 0, p_awv = 0, p_wv = 0;
  logic [AW-1:0] p_awaddr;
  logic [7:0]    p_wdata;

  always @(negedge clk) begin
    if (reset) begin
      p_aw_hs <= 0; p_w_hs <= 0; p_ar_hs <= 0; p_awv <= 0; p_wv <= 0;
    end else begin
      if (p_aw_hs) chk("awvalid_drop", AWVALID, 0);
      if (p_w_hs)  chk("wvalid_drop", WVALID, 0);
      if (p_ar_hs) chk("arvalid_drop", ARVALID, 0);
      if (p_awv && AWVALID) chk("awaddr_stable", AWADDR, p_awaddr);
      if (p_wv && WVALID)   chk("wdata_stable", WDATA, p_wdata);
      if (AWVALID && AWREADY) begin aw_edge <= cyc + 1; aw_hs_n <= aw_hs_n + 1; end
      if (WVALID && WREADY)   w_edge <= cyc + 1;
      if (BVALID && BREADY)   b_edge <= cyc + 1;
      if (ARVALID && ARREADY) ar_hs_n <= ar_hs_n + 1;
      if (ARVALID)            ar_high <= ar_high + 1;
      p_aw_hs <= AWVALID && AWREADY; p_w_hs <= WVALID && WREADY; p_ar_hs <= ARVALID && ARREADY;
      p_awv <= AWVALID; p_wv <= WVALID; p_awaddr <= AWADDR; p_wdata <= WDATA;
    end
  end

  typedef struct packed {
    logic [7:0] rdata;
    logic [1:0] resp;
    logic       to;
  } exp_t;
  exp_t exp_q[$];

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                      input logic [7:0] e_rdata, input logic [1:0] e_resp, input logic e_to,
                      output int unsigned n);
    int unsigned k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1);
    n = cyc + 1;
    exp_q.push_back('{rdata: e_rdata, resp: e_resp, to: e_to});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int unsigned hold, output int unsigned rsp_edge);
    int unsigned k;
    exp_t e;
    k = 0;
    while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    rsp_edge = cyc + 1;
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", rsp_valid, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_resp", rsp_resp, e.resp);
      chk("rsp_timeout", rsp_timeout, e.to);
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, e.rdata);
      chk("hold_resp", rsp_resp, e.resp);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_next", cmd_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, AWVALID, 0);
    chk({tag, "_wvalid"}, WVALID, 0);
    chk({tag, "_arvalid"}, ARVALID, 0);
    chk({tag, "_bready"}, BREADY, 0);
    chk({tag, "_rready"}, RREADY, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_awaddr"}, AWADDR, 0);
    chk({tag, "_araddr"}, ARADDR, 0);
    chk({tag, "_wdata"}, WDATA, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_wstrb"}, WSTRB, 1);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned n, re, a0, h0, k;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    aw_dly = 0; w_dly = 1; ar_dly = 0; ar_en = 1; b_en = 1; r_force = 0;
    b_resp_v = RESP_OKAY; r_resp_v = RESP_OKAY; r_force_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);

    // Reference write: AW at N+1, W at N+2, B at N+3, response at N+4.
    send(1'b1, 1'b0, 8'h3C, 8'h00, RESP_OKAY, 1'b0, n);
    get_rsp(0, re);
    chk("wr_aw_edge", aw_edge, n + 1);
    chk("wr_w_edge", w_edge, n + 2);
    chk("wr_b_edge", b_edge, n + 3);
    chk("wr_rsp_edge", re, n + 4);

    // Read back the complement at addr 1; ARVALID for exactly one cycle.
    a0 = ar_high;
    send(1'b0, 1'b1, 8'h00, 8'hC3, RESP_OKAY, 1'b0, n);
    get_rsp(0, re);
    chk("rd_arvalid_cycles", ar_high - a0, 1);

    // W accepted before AW.
    aw_dly = 2; w_dly = 0;
    send(1'b1, 1'b0, 8'hA5, 8'h00, RESP_OKAY, 1'b0, n);
    get_rsp(0, re);
    chk("ooo_w_edge", w_edge, n + 1);
    chk("ooo_aw_edge", aw_edge, n + 3);

    // AW and W in the same cycle; exactly one response.
    aw_dly = 0; w_dly = 0; h0 = aw_hs_n;
    send(1'b1, 1'b0, 8'h5A, 8'h00, RESP_OKAY, 1'b0, n);
    get_rsp(0, re);
    chk("same_aw_edge", aw_edge, n + 1);
    chk("same_w_edge", w_edge, n + 1);
    repeat (3) @(negedge clk);
    chk("single_rsp", rsp_valid, 0);
    chk("single_aw_hs", aw_hs_n - h0, 1);
    w_dly = 1;
    send(1'b0, 1'b0, 8'h00, 8'h5A, RESP_OKAY, 1'b0, n);
    get_rsp(0, re);

    // Non-OKAY BRESP passes through.
    b_resp_v = RESP_DECERR;
    send(1'b1, 1'b1, 8'h11, 8'h00, RESP_DECERR, 1'b0, n);
    get_rsp(0, re);
    b_resp_v = RESP_OKAY;

    // ARREADY never comes: 16 waiting cycles then timeout response.
    ar_en = 0; a0 = ar_high;
    send(1'b0, 1'b0, 8'h00, 8'h00, RESP_OKAY, 1'b1, n);
    get_rsp(0, re);
    chk("to_arvalid_cycles", ar_high - a0, TO);
    chk("to_rsp_edge", re, n + TO + 1);
    ar_en = 1;

    // SLVERR read with data, held response, no retry.
    r_force = 1; r_force_data = 8'h55; r_resp_v = RESP_SLVERR; h0 = ar_hs_n;
    send(1'b0, 1'b1, 8'h00, 8'h55, RESP_SLVERR, 1'b0, n);
    get_rsp(5, re);
    chk("slverr_no_retry", ar_hs_n - h0, 1);
    r_force = 0; r_resp_v = RESP_OKAY;

    // Reset while waiting in WRESP.
    b_en = 0;
    send(1'b1, 1'b1, 8'h99, 8'h00, RESP_OKAY, 1'b0, n);
    k = 0;
    while (!BREADY && k < 20) begin @(negedge clk); k++; end
    chk("wresp_bready", BREADY, 1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; b_en = 1;
    @(negedge clk);
    chk("post_rst_no_rsp", rsp_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    send(1'b0, 1'b1, 8'h00, 8'hA5, RESP_OKAY, 1'b0, n);
    get_rsp(0, re);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
